// File: rtl/radix_response_analyzer_pkg.sv
// Shared definitions for the multiplier BIST response analyzer:
// state encoding, MISR tap mask and the default datapath width.
package radix_bist_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Analyzer states, kept as plain 2-bit constants for legacy tools.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Fibonacci taps 16,15,13,4 map to signature bits 15,14,12,3.
  localparam logic [15:0] MISR_TAP_MASK = 16'hD008;

  // One MISR step: shift left, feed back the tap parity, fold in the data.
  function automatic logic [15:0] misr_next(input logic [15:0] sig,
                                            input logic [15:0] data);
    logic fb;
    fb = ^(sig & MISR_TAP_MASK);
    return {sig[14:0], fb} ^ data;
  endfunction

endpackage

// File: rtl/radix_response_analyzer_misr16.sv
// 16-bit multiple-input signature register. Load (seed) has priority over
// enable (compact one product); asynchronous active-high reset to the seed.
module misr16
  import radix_bist_pkg::*;
#(
  parameter logic [15:0] SEED = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        enable,
  input  logic [15:0] data,
  output logic [15:0] sig
);

  logic [15:0] sig_next;

  // Next-signature selection: reseed, compact, or hold.
  always_comb begin
    // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
    sig_next = sig;
    if (load) begin
      sig_next = SEED;
    end else if (enable) begin
      sig_next = misr_next(sig, data);
    end
  end

  // Signature register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig <= SEED;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/radix_response_analyzer.sv
// Response-compaction stage for the radix-4 multiplier BIST. Folds each
// product (marked by a rising edge of ready_in) into a MISR, counts the
// products, and after N_PATTERNS compares the signature with GOLDEN.
module radix_response_analyzer
  import radix_bist_pkg::*;
#(
  parameter int          WIDTH      = DEFAULT_WIDTH,
  parameter int          N_PATTERNS = 16,
  parameter logic [15:0] SEED       = 16'h0000,
  parameter logic [15:0] GOLDEN     = 16'h0000,
  parameter int          CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             test_start,
  input  logic             ready_in,
  input  logic [WIDTH-1:0] result_in,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] pattern_cnt,
  output logic [WIDTH-1:0] last_result,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PATTERNS);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             ready_q;
  logic             cap;
  logic             cap_en;
  logic [CNT_W-1:0] cnt_inc;

  // A product is presented once per rising edge of ready_in; a held level
  // counts only once. test_start wins over a coincident capture.
  assign cap     = ready_in & ~ready_q;
  assign cap_en  = cap & (state == ST_COLLECT) & ~test_start;
  assign cnt_inc = pattern_cnt + 1'b1;

  // Ready edge-detect register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_in;
    end
  end

  // Run sequencing: a start pulse (re)starts from any state.
  always_comb begin
    state_next = state;
    if (test_start) begin
      state_next = ST_COLLECT;
    end else begin
      case (state)
        ST_COLLECT: if (cap_en && cnt_inc == LAST_CNT) state_next = ST_CHECK;
        ST_CHECK:   state_next = ST_DONE;
        default:    state_next = state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pattern counter and last captured product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_cnt <= '0;
      last_result <= '0;
    end else if (test_start) begin
      pattern_cnt <= '0;
    end else if (cap_en) begin
      pattern_cnt <= cnt_inc;
      last_result <= result_in;
    end
  end

  // Verdict: cleared on a new run, evaluated during the single CHECK cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass <= 1'b0;
    end else if (test_start) begin
      pass <= 1'b0;
    end else if (state == ST_CHECK) begin
      pass <= (signature == GOLDEN);
    end
  end

  misr16 #(
    .SEED (SEED)
  ) u_misr (
    .clk    (clk),
    .reset  (reset),
    .load   (test_start),
    .enable (cap_en),
    .data   (result_in),
    .sig    (signature)
  );

  assign busy = (state == ST_COLLECT) || (state == ST_CHECK);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_radix_response_analyzer.sv
// Self-checking bench for radix_response_analyzer: directed scenarios from
// the test plan followed by randomized runs against a behavioural model.
module tb_radix_response_analyzer;

  localparam int          WIDTH  = 16;
  localparam int          NPAT   = 2;
  localparam logic [15:0] SEED   = 16'h0000;
  localparam logic [15:0] GOLDEN = 16'h0919;
  localparam int          CNT_W  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             test_start;
  logic             ready_in;
  logic [WIDTH-1:0] result_in;
  logic [WIDTH-1:0] signature;
  logic [CNT_W-1:0] pattern_cnt;
  logic [WIDTH-1:0] last_result;
  logic             busy;
  logic             done;
  logic             pass;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: run phase as a small integer, plain bit arithmetic.
  int          m_phase;   // 0 idle, 1 collecting, 2 checking, 3 finished
  logic [15:0] m_sig;
  int          m_cnt;
  logic [15:0] m_last;
  logic        m_pass;
  logic        m_prev_ready;

  radix_response_analyzer #(
    .WIDTH      (WIDTH),
    .N_PATTERNS (NPAT),
    .SEED       (SEED),
    .GOLDEN     (GOLDEN),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .test_start  (test_start),
    .ready_in    (ready_in),
    .result_in   (result_in),
    .signature   (signature),
    .pattern_cnt (pattern_cnt),
    .last_result (last_result),
    .busy        (busy),
    .done        (done),
    .pass        (pass)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Spec formula written bit by bit: fb = s15^s14^s12^s3, {s[14:0],fb}^d.
  function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [15:0] d);
    logic [15:0] r;
    logic fb;
    fb = s[15] ^ s[14] ^ s[12] ^ s[3];
    for (int i = 15; i > 0; i--) r[i] = s[i-1];
    r[0] = fb;
    return r ^ d;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_sig = SEED; m_cnt = 0; m_last = '0; m_pass = 1'b0; m_prev_ready = 1'b0;
  endtask

  task automatic model_clock();
    bit rise;
    rise = ready_in && !m_prev_ready;
    m_prev_ready = ready_in;
    if (test_start) begin
      m_phase = 1; m_sig = SEED; m_cnt = 0; m_pass = 1'b0;
    end else if (m_phase == 1) begin
      if (rise) begin
        m_sig  = ref_step(m_sig, result_in);
        m_last = result_in;
        m_cnt++;
        if (m_cnt == NPAT) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      m_pass  = (m_sig == GOLDEN);
      m_phase = 3;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".sig"},  32'(signature),   32'(m_sig));
    check({tag, ".cnt"},  32'(pattern_cnt), 32'(m_cnt));
    check({tag, ".last"}, 32'(last_result), 32'(m_last));
    check({tag, ".busy"}, 32'(busy),        32'(m_phase == 1 || m_phase == 2));
    check({tag, ".done"}, 32'(done),        32'(m_phase == 3));
    check({tag, ".pass"}, 32'(pass),        32'(m_pass));
  endtask

  // One clock: inputs are already stable; update model, then sample 1 ns later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_clock();
    #1;
    compare_all(tag);
  endtask

  task automatic set_in(input logic st, input logic rdy, input logic [15:0] res);
    test_start = st; ready_in = rdy; result_in = res;
  endtask

  // Assert reset between clock edges and check the outputs immediately.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all(tag);
    check({tag, ".sig0"}, 32'(signature), 32'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    set_in(1'b0, 1'b0, '0);
    model_reset();
    @(posedge clk);
    #1;

    // Reset asserted mid-clock with no edge.
    async_reset("reset");

    // Ready edge in IDLE is ignored.
    set_in(1'b0, 1'b1, 16'h1234); cycle("idle_edge");
    set_in(1'b0, 1'b0, 16'h0000); cycle("idle_low");
    check("idle_cnt", 32'(pattern_cnt), 32'd0);

    // Single capture, then held ready, then pass path.
    set_in(1'b1, 1'b0, 16'd0);    cycle("start1");
    set_in(1'b0, 1'b1, 16'd1800); cycle("cap1");
    check("single_sig",  32'(signature),   32'h0708);
    check("single_cnt",  32'(pattern_cnt), 32'd1);
    check("single_last", 32'(last_result), 32'd1800);
    for (int i = 0; i < 4; i++) cycle("held");
    check("held_cnt", 32'(pattern_cnt), 32'd1);
    set_in(1'b0, 1'b0, 16'd1800); cycle("gap1");
    set_in(1'b0, 1'b1, 16'd1800); cycle("cap2");
    check("pass_sig",  32'(signature), 32'h0919);
    check("pass_busy", 32'(busy),      32'd1);
    set_in(1'b0, 1'b0, 16'd0);    cycle("check_st");
    check("pass_done", 32'(done), 32'd1);
    check("pass_pass", 32'(pass), 32'd1);

    // Spurious edge in DONE.
    set_in(1'b0, 1'b1, 16'd5);    cycle("done_edge");
    set_in(1'b0, 1'b0, 16'd5);    cycle("done_low");
    check("done_cnt", 32'(pattern_cnt), 32'd2);
    check("done_sig", 32'(signature),   32'h0919);

    // Fail path: 1800 then 1801.
    set_in(1'b1, 1'b0, 16'd0);    cycle("start2");
    set_in(1'b0, 1'b1, 16'd1800); cycle("f_cap1");
    set_in(1'b0, 1'b0, 16'd0);    cycle("f_gap");
    set_in(1'b0, 1'b1, 16'd1801); cycle("f_cap2");
    check("fail_sig", 32'(signature), 32'h0918);
    set_in(1'b0, 1'b0, 16'd0);    cycle("f_check");
    check("fail_done", 32'(done), 32'd1);
    check("fail_pass", 32'(pass), 32'd0);

    // Abort after one capture.
    set_in(1'b1, 1'b0, 16'd0);    cycle("start3");
    set_in(1'b0, 1'b1, 16'd77);   cycle("a_cap");
    set_in(1'b1, 1'b0, 16'd0);    cycle("abort");
    check("abort_sig", 32'(signature),   32'(SEED));
    check("abort_cnt", 32'(pattern_cnt), 32'd0);

    // test_start coincident with a ready rise: product dropped.
    set_in(1'b1, 1'b1, 16'd99);   cycle("collide");
    check("collide_cnt", 32'(pattern_cnt), 32'd0);
    set_in(1'b0, 1'b0, 16'd0);    cycle("collide_low");

    // Reset during COLLECT.
    set_in(1'b0, 1'b1, 16'd42);   cycle("r_cap");
    async_reset("mid_reset");
    check("mid_reset_busy", 32'(busy), 32'd0);

    // Randomized runs: random ready waveform, products and restarts.
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), 16'($urandom));
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/radix_response_analyzer.md
Name: radix_response_analyzer

Overview:
- Downstream response-compaction stage for the radix-4 8x8 multiplier BIST.
- Consumes the multiplier's 16-bit `result`/`ready` pair during a self-test run and folds each product into a 16-bit MISR signature.
- Counts the compacted patterns and, after the programmed number, compares the signature against a golden value and reports done/pass to the BIST controller.
- In functional (non-test) mode it stays idle and ignores the multiplier.

Parameters:
- WIDTH, 16, width of result and of the signature register.
- N_PATTERNS, 16, number of products compacted per test run (≥1).
- SEED, 16'h0000, value loaded into the signature at the start of a run.
- GOLDEN, 16'h0000, expected final signature; set per pattern generator and seed.
- CNT_W, 8, width of the pattern counter; must satisfy 2^CNT_W > N_PATTERNS.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- test_start  in  1  one-cycle pulse from the BIST controller: begin a new run.
- ready_in  in  1  multiplier ready; a rising edge marks result_in valid.
- result_in  in  WIDTH  multiplier product.
- signature  out  WIDTH  current MISR contents.
- pattern_cnt  out  CNT_W  number of products compacted in this run.
- last_result  out  WIDTH  most recently captured product.
- busy  out  1  high in COLLECT and CHECK.
- done  out  1  high in DONE; run finished.
- pass  out  1  valid only while done=1; 1 when signature==GOLDEN.

Behaviour:
- Reset: asynchronous, active-high (reset=1 clears immediately, independent of clk).
  - Outputs on reset: state=IDLE, signature=SEED, pattern_cnt=0, last_result=0, busy=0, done=0, pass=0, ready_q=0.
- Edge detect:
  - ready_q is ready_in registered.
  - cap = ready_in & ~ready_q.
  - A level held high for many cycles counts once.
- MISR update on cap (Fibonacci, taps 16,15,13,4):
  - fb = sig[15]^sig[14]^sig[12]^sig[3]
  - sig_next = {sig[14:0], fb} ^ result_in
  - All arithmetic is XOR only, no carries, width fixed at WIDTH.
- Latency: signature, last_result and pattern_cnt reflect a capture on the clock edge where cap=1, i.e. they are visible one cycle after ready_in rises (ready_in is sampled by both ready_q and the capture logic on the same edge).
- State machine (states IDLE, COLLECT, CHECK, DONE):
  - IDLE: captures ignored. On test_start → COLLECT with signature=SEED and pattern_cnt=0.
  - COLLECT: each cap updates the MISR, loads last_result=result_in and increments pattern_cnt. On the cap that makes pattern_cnt==N_PATTERNS → CHECK.
  - CHECK: one cycle. pass <= (signature==GOLDEN). → DONE.
  - DONE: done=1; pass, signature and pattern_cnt held; captures ignored. On test_start → COLLECT, reseeded, done=0, pass=0.
- Boundary conditions:
  - test_start in COLLECT or CHECK: aborts the run and restarts it (reseed, count 0, pass=0).
  - test_start and cap in the same cycle: test_start wins and the product is discarded.
  - Extra ready edges after the final capture: ignored; pattern_cnt never exceeds N_PATTERNS.
  - reset mid-run: returns to IDLE immediately with reset values.
  - N_PATTERNS=1: the first capture goes directly to CHECK.

Decomposition:
- Shared package radix_bist_pkg holds:
  - state enum (IDLE, COLLECT, CHECK, DONE);
  - MISR tap constants;
  - default WIDTH=16.
- One sub-module, misr16: combinational next-signature function plus register with load (seed), enable (cap) and asynchronous reset.
- FSM, edge detect and counter live in radix_response_analyzer.

Test Plan:
- Reset check: assert reset mid-clock with no clk edge → all outputs at reset values at once, signature=0x0000.
- Single capture (SEED=0): test_start, then ready rise with result_in=1800 (18*100) → next cycle signature=0x0708, pattern_cnt=1, last_result=1800.
- Pass path (N_PATTERNS=2, GOLDEN=0x0919): two ready rises each with 1800 → signature 0x0708 then 0x0919; CHECK then DONE with done=1, pass=1.
- Fail path (N_PATTERNS=2, GOLDEN=0x0919): products 1800 then 1801 → signature 0x0918; done=1, pass=0.
- Held ready and spurious edges: ready held high 5 cycles counts once; third ready edge in DONE leaves pattern_cnt=2 and signature unchanged; ready edge in IDLE is ignored.
- Abort and collision:
  - test_start after one capture → signature=SEED, pattern_cnt=0.
  - test_start coincident with a ready rise → capture dropped, pattern_cnt=0.
  - reset during COLLECT → IDLE immediately.
